// File: rtl/cim_ctrl_pkg.sv
// Shared types and default sizing for the compute-in-memory bank controller.
package cim_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 9;
  localparam int DEF_NUM_ROWS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } state_t;

  typedef enum logic {
    GNT_LOAD = 1'b0,
    GNT_READ = 1'b1
  } gnt_t;
endpackage

// File: rtl/cim_rr_arb2.sv
// Two-way round-robin arbiter; req[0]/gnt[0] is the load side, req[1]/gnt[1] the read side.
module cim_rr_arb2
  import cim_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
  gnt_t r_last_grant;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (r_last_grant == GNT_READ) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GNT_READ;
    end else if (update && (gnt != 2'b00)) begin
      r_last_grant <= gnt[1] ? GNT_READ : GNT_LOAD;
    end
  end
endmodule

// File: rtl/cim_bank_ctrl.sv
// Bank controller: arbitrates load/read bursts, drives one-hot cell enables and
// returns read words one cycle after issue.
module cim_bank_ctrl
  import cim_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_ROWS   = DEF_NUM_ROWS,
  parameter int ROW_W      = $clog2(NUM_ROWS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ld_cmd_valid,
  output logic                           ld_cmd_ready,
  input  logic [ROW_W-1:0]               ld_base,
  input  logic [ROW_W-1:0]               ld_len,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [DATA_WIDTH-1:0]          ld_data,
  output logic                           ld_done,
  input  logic                           rd_cmd_valid,
  output logic                           rd_cmd_ready,
  input  logic [ROW_W-1:0]               rd_base,
  input  logic [ROW_W-1:0]               rd_len,
  output logic                           rd_valid,
  output logic                           rd_last,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_ROWS-1:0]            cell_en,
  output logic                           cell_we,
  output logic [DATA_WIDTH-1:0]          cell_wdata,
  input  logic [NUM_ROWS*DATA_WIDTH-1:0] cell_rdata,
  output logic                           busy
);
  state_t                r_state;
  logic [ROW_W-1:0]      r_ptr;
  logic [ROW_W-1:0]      r_cnt;
  logic                  r_ld_done;
  logic                  r_rd_valid;
  logic                  r_rd_last;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [1:0]            w_gnt;
  logic                  w_idle;
  logic                  w_ld_acc;
  logic                  w_rd_acc;
  logic                  w_wr;
  logic                  w_rd_issue;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_rows [NUM_ROWS];

  cim_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({rd_cmd_valid, ld_cmd_valid}),
    .update (w_ld_acc | w_rd_acc),
    .gnt    (w_gnt)
  );

  // Readies are gated by rst so they stay low for the whole reset pulse.
  assign w_idle       = (r_state == ST_IDLE);
  assign ld_cmd_ready = w_idle && w_gnt[0] && !rst;
  assign rd_cmd_ready = w_idle && w_gnt[1] && !rst;
  assign w_ld_acc     = ld_cmd_ready && ld_cmd_valid;
  assign w_rd_acc     = rd_cmd_ready && rd_cmd_valid;

  assign w_wr         = (r_state == ST_LOAD) && ld_valid;
  assign w_rd_issue   = (r_state == ST_READ);
  assign w_last       = (r_cnt == '0);

  assign ld_ready     = (r_state == ST_LOAD);
  assign busy         = !w_idle;
  assign cell_we      = w_wr;
  assign cell_wdata   = w_wr ? ld_data : '0;
  assign ld_done      = r_ld_done;
  assign rd_valid     = r_rd_valid;
  assign rd_last      = r_rd_last;
  assign rd_data      = r_rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
      assign cell_en[gi] = (w_wr || w_rd_issue) && (r_ptr == ROW_W'(gi));
      assign w_rows[gi]  = cell_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_ld_done <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ld_acc) begin
            r_state <= ST_LOAD;
            r_ptr   <= ld_base;
            r_cnt   <= ld_len;
          end else if (w_rd_acc) begin
            r_state <= ST_READ;
            r_ptr   <= rd_base;
            r_cnt   <= rd_len;
          end
        end
        ST_LOAD: begin
          if (ld_valid) begin
            r_ptr <= r_ptr + ROW_W'(1);
            if (w_last) begin
              r_state   <= ST_IDLE;
              r_ld_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt - ROW_W'(1);
            end
          end
        end
        ST_READ: begin
          r_ptr <= r_ptr + ROW_W'(1);
          if (w_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - ROW_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Return pipeline runs independently so a new command can start while the last word drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_issue;
      r_rd_last  <= w_rd_issue && w_last;
      r_rd_data  <= w_rd_issue ? w_rows[r_ptr] : '0;
    end
  end
endmodule

// File: tb/tb_cim_bank_ctrl.sv
// Directed bench for cim_bank_ctrl with a simple register-array cell model.
module tb_cim_bank_ctrl;
  localparam int DW = 9;
  localparam int NR = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_cmd_valid, ld_cmd_ready;
  logic [RW-1:0] ld_base, ld_len;
  logic          ld_valid, ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_done;
  logic          rd_cmd_valid, rd_cmd_ready;
  logic [RW-1:0] rd_base, rd_len;
  logic          rd_valid, rd_last;
  logic [DW-1:0] rd_data;
  logic [NR-1:0] cell_en;
  logic          cell_we;
  logic [DW-1:0] cell_wdata;
  logic [NR*DW-1:0] cell_rdata;
  logic          busy;

  logic [DW-1:0] mem [NR];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cim_bank_ctrl dut (
    .clk(clk), .rst(rst),
    .ld_cmd_valid(ld_cmd_valid), .ld_cmd_ready(ld_cmd_ready),
    .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_done(ld_done),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_base(rd_base), .rd_len(rd_len),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
    .cell_en(cell_en), .cell_we(cell_we), .cell_wdata(cell_wdata),
    .cell_rdata(cell_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (cell_en[i] && cell_we) mem[i] <= cell_wdata;
    end
  end

  always_comb begin
    cell_rdata = '0;
    for (int i = 0; i < NR; i++) cell_rdata[i*DW +: DW] = mem[i];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int row);
    logic [NR-1:0] v;
    v = 1;
    return v << (row % NR);
  endfunction

  initial begin
    logic [DW-1:0] dat [3];
    logic          pat [5];
    int            j;
    int            row;
    dat = '{9'h0AA, 9'h1AB, 9'h0CC};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    ld_cmd_valid = 1'b1; rd_cmd_valid = 1'b1;
    ld_base = '0; ld_len = '0; rd_base = '0; rd_len = '0;
    ld_valid = 1'b1; ld_data = 9'h1FF;
    repeat (2) @(negedge clk);
    chk("rst_ld_cmd_ready", ld_cmd_ready, 0);
    chk("rst_rd_cmd_ready", rd_cmd_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_cell_en", cell_en, 0);
    chk("rst_cell_we", cell_we, 0);
    chk("rst_cell_wdata", cell_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ld_done", ld_done, 0);

    // First tie after reset: load wins
    rst = 1'b0; ld_valid = 1'b0;
    ld_base = 4'd0; ld_len = 4'd15; rd_base = 4'd14; rd_len = 4'd3;
    #1;
    chk("tie1_ld_cmd_ready", ld_cmd_ready, 1);
    chk("tie1_rd_cmd_ready", rd_cmd_ready, 0);
    $display("cmd LOAD base=0 len=15");
    @(negedge clk);
    ld_cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_data = DW'(9'h100 + i);
      #1;
      chk("ld16_cell_en", cell_en, onehot(i));
      chk("ld16_cell_we", cell_we, 1);
      chk("ld16_cell_wdata", cell_wdata, 32'h100 + i);
      chk("ld16_rd_cmd_ready", rd_cmd_ready, 0);
      chk("ld16_ld_done", ld_done, 0);
      @(negedge clk);
    end

    // Second tie: read wins
    ld_valid = 1'b0; ld_cmd_valid = 1'b1; ld_base = 4'd4; ld_len = 4'd2;
    #1;
    chk("ld16_done_pulse", ld_done, 1);
    chk("ld16_busy_after", busy, 0);
    chk("tie2_rd_cmd_ready", rd_cmd_ready, 1);
    chk("tie2_ld_cmd_ready", ld_cmd_ready, 0);
    $display("cmd READ base=14 len=3");
    @(negedge clk);
    rd_cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      row = (14 + k) % NR;
      #1;
      chk("rdw_cell_en", cell_en, onehot(row));
      chk("rdw_cell_we", cell_we, 0);
      chk("rdw_rd_valid", rd_valid, (k > 0) ? 1 : 0);
      chk("rdw_rd_data", rd_data, (k > 0) ? (32'h100 + ((row + NR - 1) % NR)) : 0);
      chk("rdw_rd_last", rd_last, 0);
      chk("rdw_ld_cmd_ready", ld_cmd_ready, 0);
      chk("rdw_ld_done_low", ld_done, 0);
      @(negedge clk);
    end
    #1;
    chk("rdw_final_valid", rd_valid, 1);
    chk("rdw_final_last", rd_last, 1);
    chk("rdw_final_data", rd_data, 32'h101);
    chk("rdw_busy_after", busy, 0);
    chk("overlap_ld_cmd_ready", ld_cmd_ready, 1);
    $display("cmd LOAD base=4 len=2 with bubbles");
    @(negedge clk);
    ld_cmd_valid = 1'b0;
    j = 0;
    for (int c = 0; c < 5; c++) begin
      ld_valid = pat[c];
      ld_data  = pat[c] ? dat[j] : 9'h155;
      #1;
      chk("bub_busy", busy, 1);
      chk("bub_cell_we", cell_we, pat[c]);
      chk("bub_cell_en", cell_en, pat[c] ? onehot(4 + j) : '0);
      chk("bub_ld_done", ld_done, 0);
      @(negedge clk);
      if (pat[c]) j++;
    end
    ld_valid = 1'b0;
    rd_cmd_valid = 1'b1; rd_base = 4'd5; rd_len = 4'd1;
    #1;
    chk("bub_busy_after", busy, 0);
    chk("bub_ld_done", ld_done, 1);
    chk("raw_rd_cmd_ready", rd_cmd_ready, 1);
    $display("cmd READ base=5 len=1");
    @(negedge clk);
    rd_cmd_valid = 1'b0;
    #1;
    chk("raw_cell_en5", cell_en, onehot(5));
    @(negedge clk);
    #1;
    chk("raw_cell_en6", cell_en, onehot(6));
    chk("raw_rd_valid5", rd_valid, 1);
    chk("raw_rd_data5", rd_data, 32'h1AB);
    @(negedge clk);
    #1;
    chk("raw_rd_data6", rd_data, 32'h0CC);
    chk("raw_rd_last6", rd_last, 1);

    // Read burst of 8 aborted by reset after two issues
    rd_cmd_valid = 1'b1; rd_base = 4'd0; rd_len = 4'd7;
    $display("cmd READ base=0 len=7 aborted by reset");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_cell_en", cell_en, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_rd_data", rd_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd_cmd_ready", rd_cmd_ready, 0);
    @(negedge clk);
    chk("abort_busy2", busy, 0);
    chk("abort_rd_last", rd_last, 0);
    rst = 1'b0;
    #1;
    chk("abort_rd_cmd_ready_after", rd_cmd_ready, 1);
    chk("abort_ld_cmd_ready_after", ld_cmd_ready, 0);
    rd_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cim_bank_ctrl.md
CIM_BANK_CTRL -- requirements
Module: cim_bank_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: DATA_WIDTH, 9, cell word width (bit 0 = metadata).
REQ-003 Parameter: NUM_ROWS, 16, cells in bank, power of two.
REQ-004 Parameter: ROW_W, $clog2(NUM_ROWS), row index width.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  async active-high reset.
REQ-007 Port: ld_cmd_valid / ld_cmd_ready  in / out  1 / 1  load command handshake.
REQ-008 Port: ld_base / ld_len  in  ROW_W / ROW_W  first row; row count minus 1.
REQ-009 Port: ld_valid / ld_ready  in / out  1 / 1  load-data beat handshake.
REQ-010 Port: ld_data  in  DATA_WIDTH  weight word for current row.
REQ-011 Port: ld_done  out  1  one-cycle pulse on final accepted load beat.
REQ-012 Port: rd_cmd_valid / rd_cmd_ready  in / out  1 / 1  read command handshake.
REQ-013 Port: rd_base / rd_len  in  ROW_W / ROW_W  first row; row count minus 1.
REQ-014 Port: rd_valid / rd_last  out  1 / 1  read data valid; final word of burst.
REQ-015 Port: rd_data  out  DATA_WIDTH  read word.
REQ-016 Port: cell_en  out  NUM_ROWS  one-hot per-cell enable; all-zero when idle.
REQ-017 Port: cell_we / cell_wdata  out  1 / DATA_WIDTH  shared write enable and data line.
REQ-018 Port: cell_rdata  in  NUM_ROWS*DATA_WIDTH  concatenated cell read_out, row 0 at LSBs.
REQ-019 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, LOAD, READ.
REQ-021 ld_cmd_ready and rd_cmd_ready SHALL be high only in IDLE, and at most one SHALL be high per cycle, per the grant.
REQ-022 Grant rule: one requester valid -> grant it; both valid -> round-robin; winner recorded in last_grant.
REQ-023 Command accepted in cycle N -> state changes at edge N; first cell access in cycle N+1.
REQ-024 LOAD: ld_ready=1; each cycle with ld_valid&&ld_ready drives cell_en one-hot at ptr, cell_we=1, cell_wdata=ld_data (combinational), then increments ptr.
REQ-025 LOAD with ld_valid=0: cell_en=0, cell_we=0, ptr holds; bubbles are unbounded.
REQ-026 READ: one row per cycle, no stall; cell_en one-hot at ptr, cell_we=0.
REQ-027 Read latency SHALL be 1 cycle: rd_valid, rd_last, and rd_data = cell_rdata slice of the row issued in the previous cycle.
REQ-028 rd_data SHALL be 0 when rd_valid=0.
REQ-029 ptr SHALL wrap modulo NUM_ROWS, e.g. base 14, len 3 -> rows 14, 15, 0, 1.
REQ-030 Remaining counter loads len; the beat issued at count 0 is last; the FSM returns to IDLE at that edge.
REQ-031 ld_done SHALL pulse in the cycle after the last load beat is accepted.
REQ-032 A new command may be accepted in the IDLE cycle that follows a burst, while the prior read's rd_valid is still in flight; the return pipeline is independent of the FSM.
REQ-033 A read issued to a row in the cycle after that row was written SHALL return the new value.
REQ-034 rd_len and ld_len SHALL support a full NUM_ROWS burst; no illegal encodings.

Reset
REQ-035 While rst is high: state IDLE, ptr 0, counter 0, last_grant=READ (so LOAD wins the first tie).
REQ-036 While rst is high, all outputs SHALL be 0: cell_en, cell_we, cell_wdata, rd_valid, rd_last, rd_data, ld_done, ready signals, busy.
REQ-037 A burst aborted by reset SHALL be discarded, with no resume and no ld_done.

Structure
REQ-038 Shared package cim_ctrl_pkg SHALL hold the state enum, the grant enum (GNT_LOAD/GNT_READ), and the default DATA_WIDTH/NUM_ROWS.
REQ-039 The 2-way round-robin SHALL be the sub-module cim_rr_arb2 (req[1:0], gnt[1:0], update strobe).
REQ-040 The rd_data mux and 1-cycle return register SHALL stay inline.

Verification
REQ-041 ld_base=0, ld_len=15, 16 back-to-back beats 0x100+i -> cell_en walks bit0..bit15, cell_we=1, ld_done 1 cycle after 16th beat.
REQ-042 Preloaded cells, rd_base=14, rd_len=3 -> cell_en bits 14, 15, 0, 1; rd_valid 4 cycles, each 1 cycle after issue; rd_last on 4th.
REQ-043 ld and rd commands valid simultaneously twice after reset -> LOAD granted first, READ second; ready never both high.
REQ-044 Load of 3 rows with ld_valid toggling 1,0,0,1,1 -> 3 writes only, ptr holds during bubbles, busy high for 5 cycles.
REQ-045 rst asserted mid-READ after 2 of 8 rows -> next cycle all outputs 0, state IDLE, rd_cmd_ready=1 once rst drops.
REQ-046 Write row 5 = 0x1AB, then read row 5 in the next accepted command -> rd_data=0x1AB.
